// File: rtl/fast_circle_fetch_if.sv
// rtl/fast_circle_fetch_if.sv - fetch request, pixel stream, writer and SRAM port bundle
interface fast_circle_fetch_if #(
   parameter int PIXEL_DEPTH = 8,
   parameter int X_MAX       = 64,
   parameter int Y_MAX       = 48
);
   localparam int XW = $clog2(X_MAX) + 1;
   localparam int YW = $clog2(Y_MAX) + 1;

   logic                   start;
   logic signed [XW-1:0]   cx;
   logic signed [YW-1:0]   cy;
   logic                   busy;
   logic                   done;
   logic                   px_valid;
   logic [4:0]             px_idx;
   logic [PIXEL_DEPTH-1:0] px_data;
   logic                   wr_req;
   logic signed [XW-1:0]   wr_x;
   logic signed [YW-1:0]   wr_y;
   logic [PIXEL_DEPTH-1:0] wr_data;
   logic                   wr_gnt;
   logic [XW-1:0]          sram_x_addr;
   logic [YW-1:0]          sram_y_addr;
   logic                   sram_ren;
   logic                   sram_wen;
   logic [PIXEL_DEPTH-1:0] sram_wdat;
   logic [PIXEL_DEPTH-1:0] sram_rdat;

   modport slave (
      input  start, cx, cy, wr_req, wr_x, wr_y, wr_data, sram_rdat,
      output busy, done, px_valid, px_idx, px_data, wr_gnt,
             sram_x_addr, sram_y_addr, sram_ren, sram_wen, sram_wdat
   );

   modport master (
      output start, cx, cy, wr_req, wr_x, wr_y, wr_data, sram_rdat,
      input  busy, done, px_valid, px_idx, px_data, wr_gnt,
             sram_x_addr, sram_y_addr, sram_ren, sram_wen, sram_wdat
   );
endinterface

// File: rtl/fast_circle_fetch.sv
// rtl/fast_circle_fetch.sv - FAST radius-3 circle pixel fetcher sharing one SRAM port with a writer
module fast_circle_fetch #(
   parameter int PIXEL_DEPTH = 8,
   parameter int X_MAX       = 64,
   parameter int Y_MAX       = 48
) (
   input logic                 clk,
   input logic                 n_rst,
   fast_circle_fetch_if.slave  bus
);
   localparam int XW = $clog2(X_MAX) + 1;
   localparam int YW = $clog2(Y_MAX) + 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   state_t               state_q, state_d;
   logic signed [XW-1:0] cx_q, cx_d;
   logic signed [YW-1:0] cy_q, cy_d;
   logic [4:0]           idx_q, idx_d;
   logic                 rr_wr_q, rr_wr_d;
   logic                 pv_q, pv_d;
   logic [4:0]           pidx_q, pidx_d;
   logic                 poob_q, poob_d;
   logic [XW-1:0]        ax_q, ax_d;
   logic [YW-1:0]        ay_q, ay_d;

   logic [3:0]           dx, dy;
   logic signed [XW:0]   rd_x;
   logic signed [YW:0]   rd_y;
   logic                 rd_oob, wr_oob, wr_win, rd_issue;

   // Circle offsets as 4-bit two's complement; idx 0 is the centre
   always_comb begin
      dx = 4'h0;
      dy = 4'h0;
      case (idx_q)
         5'd1:  begin dx = 4'h0; dy = 4'hD; end
         5'd2:  begin dx = 4'h1; dy = 4'hD; end
         5'd3:  begin dx = 4'h2; dy = 4'hE; end
         5'd4:  begin dx = 4'h3; dy = 4'hF; end
         5'd5:  begin dx = 4'h3; dy = 4'h0; end
         5'd6:  begin dx = 4'h3; dy = 4'h1; end
         5'd7:  begin dx = 4'h2; dy = 4'h2; end
         5'd8:  begin dx = 4'h1; dy = 4'h3; end
         5'd9:  begin dx = 4'h0; dy = 4'h3; end
         5'd10: begin dx = 4'hF; dy = 4'h3; end
         5'd11: begin dx = 4'hE; dy = 4'h2; end
         5'd12: begin dx = 4'hD; dy = 4'h1; end
         5'd13: begin dx = 4'hD; dy = 4'h0; end
         5'd14: begin dx = 4'hD; dy = 4'hF; end
         5'd15: begin dx = 4'hE; dy = 4'hE; end
         5'd16: begin dx = 4'hF; dy = 4'hD; end
         default: begin dx = 4'h0; dy = 4'h0; end
      endcase
   end

   // One extra bit of width so centre+offset never wraps into the image
   assign rd_x   = {cx_q[XW-1], cx_q} + {{(XW-3){dx[3]}}, dx};
   assign rd_y   = {cy_q[YW-1], cy_q} + {{(YW-3){dy[3]}}, dy};
   assign rd_oob = rd_x[XW] | (rd_x[XW-1:0] > XW'(X_MAX - 1)) |
                   rd_y[YW] | (rd_y[YW-1:0] > YW'(Y_MAX - 1));
   assign wr_oob = bus.wr_x[XW-1] | (bus.wr_x > XW'(X_MAX - 1)) |
                   bus.wr_y[YW-1] | (bus.wr_y > YW'(Y_MAX - 1));

   always_comb begin
      state_d  = state_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      idx_d    = idx_q;
      rr_wr_d  = rr_wr_q;
      pv_d     = 1'b0;
      pidx_d   = pidx_q;
      poob_d   = 1'b0;
      wr_win   = 1'b0;
      rd_issue = 1'b0;
      case (state_q)
         S_IDLE: begin
            wr_win = bus.wr_req;
            if (bus.start) begin
               cx_d    = bus.cx;
               cy_d    = bus.cy;
               idx_d   = 5'd0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.wr_req && !rr_wr_q) begin
               wr_win  = 1'b1;
               rr_wr_d = 1'b1;
            end else begin
               rd_issue = 1'b1;
               if (bus.wr_req) rr_wr_d = 1'b0;
            end
            if (rd_issue) begin
               pv_d   = 1'b1;
               pidx_d = idx_q;
               poob_d = rd_oob;
               idx_d  = idx_q + 5'd1;
               if (idx_q == 5'd16) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            wr_win  = bus.wr_req;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Address lines hold their last value when the port is idle
   always_comb begin
      ax_d = ax_q;
      ay_d = ay_q;
      if (wr_win) begin
         ax_d = bus.wr_x;
         ay_d = bus.wr_y;
      end else if (rd_issue) begin
         ax_d = rd_x[XW-1:0];
         ay_d = rd_y[YW-1:0];
      end
   end

   assign bus.sram_x_addr = ax_d;
   assign bus.sram_y_addr = ay_d;
   assign bus.sram_ren    = rd_issue & ~rd_oob;
   assign bus.sram_wen    = wr_win & ~wr_oob;
   assign bus.sram_wdat   = bus.wr_data;
   assign bus.wr_gnt      = wr_win;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.px_valid    = pv_q;
   assign bus.px_idx      = pv_q ? pidx_q : 5'd0;
   assign bus.px_data     = (pv_q && !poob_q) ? bus.sram_rdat : '0;
   assign bus.done        = pv_q && (pidx_q == 5'd16);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         cx_q    <= '0;
         cy_q    <= '0;
         idx_q   <= '0;
         rr_wr_q <= 1'b0;
         pv_q    <= 1'b0;
         pidx_q  <= '0;
         poob_q  <= 1'b0;
         ax_q    <= '0;
         ay_q    <= '0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         idx_q   <= idx_d;
         rr_wr_q <= rr_wr_d;
         pv_q    <= pv_d;
         pidx_q  <= pidx_d;
         poob_q  <= poob_d;
         ax_q    <= ax_d;
         ay_q    <= ay_d;
      end
   end
endmodule
